// File: rtl/vedic_pkg.sv
// Shared types and constants for the sequential restoring divider.
package vedic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N = 3;

  // Wide enough for any practical N; users slice the low 2N bits.
  localparam logic [63:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/vedic_seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface vedic_seq_divider_if
  import vedic_pkg::*;
#(
  parameter int N = DEF_N
);

  logic             start;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   quotient;
  logic [N-1:0]     remainder;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );

endinterface

// File: rtl/vedic_seq_divider_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial subtract.
module div_step
  import vedic_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] r_in,
  input  logic         d_msb,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] r_out,
  output logic         q_bit
);

  logic [N:0] r_shift;
  logic [N:0] trial;

  // The running remainder is always below the divisor, so N bits hold either outcome.
  always_comb begin
    r_shift = {r_in, d_msb};
    trial   = r_shift - {1'b0, divisor};
    q_bit   = ~trial[N];
    r_out   = q_bit ? trial[N-1:0] : r_shift[N-1:0];
  end

endmodule

// File: rtl/vedic_seq_divider.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per clock.
module vedic_seq_divider
  import vedic_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic                clk,
  input  logic                rst_n,
  vedic_seq_divider_if.slave  bus
);

  localparam int              CW   = $clog2(2*N) + 1;
  localparam logic [CW-1:0]   LAST = CW'(2*N - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    r_reg;
  logic [N-1:0]    dvs_reg;
  logic [2*N-1:0]  d_reg;
  logic [N-1:0]    r_next;
  logic            q_bit;

  div_step #(.N(N)) u_step (
    .r_in    (r_reg),
    .d_msb   (d_reg[2*N-1]),
    .divisor (dvs_reg),
    .r_out   (r_next),
    .q_bit   (q_bit)
  );

  // Work registers are separate from the result outputs, which only change on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      r_reg         <= '0;
      dvs_reg       <= '0;
      d_reg         <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            d_reg   <= bus.dividend;
            dvs_reg <= bus.divisor;
            r_reg   <= '0;
            cnt     <= '0;
            if (bus.divisor == '0) begin
              state         <= DONE;
              bus.done      <= 1'b1;
              bus.quotient  <= DIV_ZERO_Q[2*N-1:0];
              bus.remainder <= '0;
              bus.div_zero  <= 1'b1;
            end else begin
              state    <= RUN;
              bus.busy <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          r_reg <= r_next;
          d_reg <= {d_reg[2*N-2:0], q_bit};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.quotient  <= {d_reg[2*N-2:0], q_bit};
            bus.remainder <= r_next;
            bus.div_zero  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_seq_divider.sv
// Self-checking bench for vedic_seq_divider: directed table, corner sequences, sweeps and random ops.
module tb_vedic_seq_divider;
  import vedic_pkg::*;

  localparam int N   = 3;
  localparam int LAT = 2*N + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   model_q, model_r, model_dz;

  vedic_seq_divider_if #(.N(N)) bus ();

  vedic_seq_divider #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dvd;
    int dvs;
    int q;
    int r;
    int dz;
    int lat;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int dvd, input int dvs, input bit b2b);
    if (!b2b) @(negedge clk);
    bus.dividend = dvd[2*N-1:0];
    bus.divisor  = dvs[N-1:0];
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Expected values come from plain integer division; the previous result is the hold reference.
  task automatic runOp(input int dvd, input int dvs, input bit b2b, input int inj_at,
                       output int obs_q, output int obs_r);
    int eq, er, edz, elat, lat;
    if (dvs == 0) begin
      eq = (1 << (2*N)) - 1; er = 0; edz = 1; elat = 1;
    end else begin
      eq = dvd / dvs; er = dvd % dvs; edz = 0; elat = LAT;
    end
    applyStimulus(dvd, dvs, b2b);
    lat = 0;
    for (int i = 1; i <= 4*LAT; i++) begin
      @(negedge clk);
      bus.start = (i == inj_at);
      if (i == inj_at) begin
        bus.dividend = 6'd9;
        bus.divisor  = 3'd2;
      end
      if (i == 1) checkOutput("busy_first", int'(bus.busy), (dvs != 0) ? 1 : 0);
      if (i == 3 && dvs != 0) begin
        checkOutput("hold_q", int'(bus.quotient), model_q);
        checkOutput("hold_dz", int'(bus.div_zero), model_dz);
      end
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    checkOutput("latency", lat, elat);
    checkOutput("quotient", int'(bus.quotient), eq);
    checkOutput("remainder", int'(bus.remainder), er);
    checkOutput("div_zero", int'(bus.div_zero), edz);
    obs_q = int'(bus.quotient);
    obs_r = int'(bus.remainder);
    model_q = eq; model_r = er; model_dz = edz;
  endtask

  initial begin
    int  oq, orr, dvd, dvs;
    bit  first, seen_done;

    vecs[0] = '{45, 5,  9, 0, 0, LAT};
    vecs[1] = '{50, 7,  7, 1, 0, LAT};
    vecs[2] = '{63, 1, 63, 0, 0, LAT};
    vecs[3] = '{ 0, 3,  0, 0, 0, LAT};
    vecs[4] = '{12, 0, 63, 0, 1, 1};
    vecs[5] = '{20, 3,  6, 2, 0, LAT};

    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_quotient", int'(bus.quotient), 0);
    checkOutput("rst_remainder", int'(bus.remainder), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_done", int'(bus.done), 0);
    checkOutput("rst_div_zero", int'(bus.div_zero), 0);
    model_q = 0; model_r = 0; model_dz = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      runOp(vecs[k].dvd, vecs[k].dvs, 1'b0, 0, oq, orr);
      checkOutput("vec_q", oq, vecs[k].q);
      checkOutput("vec_r", orr, vecs[k].r);
      @(negedge clk);
      checkOutput("done_pulse", int'(bus.done), 0);
    end

    // A start during RUN must be dropped without disturbing the running operation.
    runOp(45, 5, 1'b0, 3, oq, orr);
    checkOutput("midrun_q", oq, 9);
    @(negedge clk);
    checkOutput("midrun_done_low", int'(bus.done), 0);
    checkOutput("midrun_busy_low", int'(bus.busy), 0);

    runOp(50, 7, 1'b0, 0, oq, orr);
    applyStimulus(45, 5, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_quotient", int'(bus.quotient), 0);
    checkOutput("midrst_remainder", int'(bus.remainder), 0);
    checkOutput("midrst_busy", int'(bus.busy), 0);
    checkOutput("midrst_done", int'(bus.done), 0);
    checkOutput("midrst_div_zero", int'(bus.div_zero), 0);
    model_q = 0; model_r = 0; model_dz = 0;
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (2*LAT) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    checkOutput("midrst_no_done", int'(seen_done), 0);
    runOp(33, 4, 1'b0, 0, oq, orr);
    checkOutput("after_rst_q", oq, 8);
    checkOutput("after_rst_r", orr, 1);

    first = 1'b1;
    for (int a = 0; a < 64; a++) begin
      for (int b = 1; b < 8; b++) begin
        runOp(a, b, !first, 0, oq, orr);
        first = 1'b0;
        checkOutput("recon", oq*b + orr, a);
        checkOutput("rem_lt_div", (orr < b) ? 1 : 0, 1);
      end
    end

    for (int a = 0; a < 8; a++) begin
      for (int b = 1; b < 8; b++) begin
        runOp(a*b, b, 1'b1, 0, oq, orr);
        checkOutput("vedic_rt_q", oq, a);
        checkOutput("vedic_rt_r", orr, 0);
      end
    end

    for (int n = 0; n < 150; n++) begin
      dvd = int'($urandom_range(0, 63));
      dvs = int'($urandom_range(0, 7));
      runOp(dvd, dvs, 1'($urandom_range(0, 1)), 0, oq, orr);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
